// File: rtl/lc4_div_pkg.sv
// Shared types and helpers for the LC4 iterative divider.
package lc4_div_pkg;

  localparam int unsigned DIV_WIDTH = 16;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  // Ceiling log2 with a floor of 1 so a single-iteration counter still has a bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/lc4_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial subtract.
module lc4_div_step
  import lc4_div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] dvd_i,
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] dvd_o,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] rem_t;
  logic             ge;

  always_comb begin
    rem_t = (rem_i << 1) | WIDTH'(dvd_i[WIDTH-1]);
    ge    = (rem_t >= divisor_i);
    dvd_o = dvd_i << 1;
    rem_o = ge ? (rem_t - divisor_i) : rem_t;
    q_o   = (q_i << 1) | WIDTH'(ge);
  end

endmodule

// File: rtl/lc4_div_sequencer.sv
// Multi-cycle unsigned DIV/MOD unit: valid/ready operand intake, restoring steps, held result.
module lc4_div_sequencer
  import lc4_div_pkg::*;
#(
  parameter int unsigned WIDTH           = DIV_WIDTH,
  parameter int unsigned STEPS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_busy
);

  localparam int unsigned ITERS = WIDTH / STEPS_PER_CYCLE;
  localparam int unsigned CW    = clog2(ITERS);
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

  div_state_t       state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d, rem_q, rem_d, q_q, q_d, dsr_q, dsr_d;
  logic [WIDTH-1:0] quot_q, quot_d, remd_q, remd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             accept, advance, last_iter;
  logic [WIDTH-1:0] dvd_n, rem_n, q_n;

  assign accept    = (state_q == DIV_IDLE) && i_valid && !i_flush;
  assign advance   = (state_q == DIV_RUN) && !i_flush;
  assign last_iter = (cnt_q == LAST);

  // Chain of restoring steps evaluated within one clock.
  for (genvar g = 0; g < STEPS_PER_CYCLE; g++) begin : g_step
    logic [WIDTH-1:0] dvd_in, rem_in, q_in, dvd_out, rem_out, q_out;
    if (g == 0) begin : g_first
      assign dvd_in = dvd_q;
      assign rem_in = rem_q;
      assign q_in   = q_q;
    end else begin : g_next
      assign dvd_in = g_step[g-1].dvd_out;
      assign rem_in = g_step[g-1].rem_out;
      assign q_in   = g_step[g-1].q_out;
    end
    lc4_div_step #(.WIDTH(WIDTH)) u_step (
      .dvd_i    (dvd_in),
      .rem_i    (rem_in),
      .q_i      (q_in),
      .divisor_i(dsr_q),
      .dvd_o    (dvd_out),
      .rem_o    (rem_out),
      .q_o      (q_out)
    );
  end

  assign dvd_n = g_step[STEPS_PER_CYCLE-1].dvd_out;
  assign rem_n = g_step[STEPS_PER_CYCLE-1].rem_out;
  assign q_n   = g_step[STEPS_PER_CYCLE-1].q_out;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= DIV_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (i_flush) begin
      state_d = DIV_IDLE;
    end else begin
      unique case (state_q)
        DIV_IDLE: if (i_valid) state_d = (i_divisor == '0) ? DIV_DONE : DIV_RUN;
        DIV_RUN:  if (last_iter) state_d = DIV_DONE;
        DIV_DONE: if (i_out_ready) state_d = DIV_IDLE;
        default:  state_d = DIV_IDLE;
      endcase
    end
  end

  always_comb begin
    o_ready = (state_q == DIV_IDLE);
    o_valid = (state_q == DIV_DONE);
    o_busy  = (state_q == DIV_RUN) || (state_q == DIV_DONE);
  end

  assign o_quotient  = quot_q;
  assign o_remainder = remd_q;

  // Working and result registers; results only change on a zero-divide accept or the final step.
  always_comb begin
    dvd_d  = dvd_q;
    rem_d  = rem_q;
    q_d    = q_q;
    dsr_d  = dsr_q;
    cnt_d  = cnt_q;
    quot_d = quot_q;
    remd_d = remd_q;
    if (accept) begin
      dvd_d = i_dividend;
      dsr_d = i_divisor;
      rem_d = '0;
      q_d   = '0;
      cnt_d = '0;
      if (i_divisor == '0) begin
        quot_d = '0;
        remd_d = '0;
      end
    end else if (advance) begin
      dvd_d = dvd_n;
      rem_d = rem_n;
      q_d   = q_n;
      cnt_d = cnt_q + CW'(1);
      if (last_iter) begin
        quot_d = q_n;
        remd_d = rem_n;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dvd_q  <= '0;
      rem_q  <= '0;
      q_q    <= '0;
      dsr_q  <= '0;
      cnt_q  <= '0;
      quot_q <= '0;
      remd_q <= '0;
    end else begin
      dvd_q  <= dvd_d;
      rem_q  <= rem_d;
      q_q    <= q_d;
      dsr_q  <= dsr_d;
      cnt_q  <= cnt_d;
      quot_q <= quot_d;
      remd_q <= remd_d;
    end
  end

endmodule

// File: tb/tb_lc4_div_sequencer.sv
// Directed and randomised checks of lc4_div_sequencer at one and four steps per cycle.
module tb_lc4_div_sequencer;

  localparam int unsigned W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         a_flush, a_valid, a_ready, a_ovalid, a_out_ready, a_busy;
  logic [W-1:0] a_dividend, a_divisor, a_quot, a_rem;
  logic         b_flush, b_valid, b_ready, b_ovalid, b_out_ready, b_busy;
  logic [W-1:0] b_dividend, b_divisor, b_quot, b_rem;

  int total  = 0;
  int passed = 0;

  lc4_div_sequencer #(.WIDTH(W), .STEPS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .i_flush(a_flush), .i_valid(a_valid), .o_ready(a_ready),
    .i_dividend(a_dividend), .i_divisor(a_divisor), .o_valid(a_ovalid),
    .i_out_ready(a_out_ready), .o_quotient(a_quot), .o_remainder(a_rem), .o_busy(a_busy)
  );

  lc4_div_sequencer #(.WIDTH(W), .STEPS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .i_flush(b_flush), .i_valid(b_valid), .o_ready(b_ready),
    .i_dividend(b_dividend), .i_divisor(b_divisor), .o_valid(b_ovalid),
    .i_out_ready(b_out_ready), .o_quotient(b_quot), .o_remainder(b_rem), .o_busy(b_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_accept(input logic [W-1:0] dvd, input logic [W-1:0] dsr);
    a_dividend = dvd;
    a_divisor  = dsr;
    a_valid    = 1'b1;
    tick();
    a_valid    = 1'b0;
    a_dividend = 16'hDEAD;
    a_divisor  = 16'h0000;
  endtask

  task automatic a_wait(output int n);
    n = 0;
    while (a_ovalid !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
  endtask

  task automatic b_accept(input logic [W-1:0] dvd, input logic [W-1:0] dsr);
    b_dividend = dvd;
    b_divisor  = dsr;
    b_valid    = 1'b1;
    tick();
    b_valid    = 1'b0;
    b_dividend = 16'hBEEF;
    b_divisor  = 16'h0000;
  endtask

  task automatic b_wait(output int n);
    n = 0;
    while (b_ovalid !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    total++; if (a_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", a_ready); else passed++;
    total++; if (a_ovalid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", a_ovalid); else passed++;
    total++; if (a_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", a_busy); else passed++;
    total++; if ({a_quot, a_rem} !== 32'h0) $display("FAIL reset_result: got %h expected 00000000", {a_quot, a_rem}); else passed++;
    total++; if ({b_ready, b_ovalid, b_busy} !== 3'b100) $display("FAIL reset_s4_flags: got %b expected 100", {b_ready, b_ovalid, b_busy}); else passed++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int n;
    a_out_ready = 1'b1;
    a_accept(16'd100, 16'd7);
    total++; if (a_busy !== 1'b1 || a_ready !== 1'b0) $display("FAIL basic_run_flags: got busy=%b ready=%b expected busy=1 ready=0", a_busy, a_ready); else passed++;
    a_wait(n);
    total++; if (n !== 16) $display("FAIL basic_latency: got %0d expected 16", n); else passed++;
    total++; if (a_quot !== 16'd14) $display("FAIL basic_quotient: got %0d expected 14", a_quot); else passed++;
    total++; if (a_rem !== 16'd2) $display("FAIL basic_remainder: got %0d expected 2", a_rem); else passed++;
    total++; if (a_ready !== 1'b0 || a_busy !== 1'b1) $display("FAIL basic_done_flags: got ready=%b busy=%b expected 0 1", a_ready, a_busy); else passed++;
    tick();
    total++; if ({a_ovalid, a_ready, a_busy} !== 3'b010) $display("FAIL basic_retire: got %b expected 010", {a_ovalid, a_ready, a_busy}); else passed++;
    total++; if ({a_quot, a_rem} !== {16'd14, 16'd2}) $display("FAIL basic_hold_idle: got %h expected 000e0002", {a_quot, a_rem}); else passed++;
  endtask

  task automatic test_div_zero();
    int n;
    a_out_ready = 1'b1;
    a_accept(16'h1234, 16'h0000);
    a_wait(n);
    total++; if (n !== 0) $display("FAIL divzero_latency: got %0d expected 0", n); else passed++;
    total++; if ({a_quot, a_rem} !== 32'h0) $display("FAIL divzero_result: got %h expected 00000000", {a_quot, a_rem}); else passed++;
    total++; if (a_busy !== 1'b1) $display("FAIL divzero_busy: got %b expected 1", a_busy); else passed++;
    tick();
    total++; if ({a_busy, a_ready} !== 2'b01) $display("FAIL divzero_retire: got %b expected 01", {a_busy, a_ready}); else passed++;
  endtask

  task automatic test_extremes();
    logic [W-1:0] xd [4] = '{16'hFFFF, 16'h0005, 16'hFFFF, 16'h0000};
    logic [W-1:0] xs [4] = '{16'h0001, 16'hFFFF, 16'hFFFF, 16'h0003};
    logic [W-1:0] eq [4] = '{16'hFFFF, 16'h0000, 16'h0001, 16'h0000};
    logic [W-1:0] er [4] = '{16'h0000, 16'h0005, 16'h0000, 16'h0000};
    int n;
    a_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_accept(xd[i], xs[i]);
      a_wait(n);
      total++; if (n !== 16) $display("FAIL extreme%0d_latency: got %0d expected 16", i, n); else passed++;
      total++; if ({a_quot, a_rem} !== {eq[i], er[i]}) $display("FAIL extreme%0d_result: got %h expected %h", i, {a_quot, a_rem}, {eq[i], er[i]}); else passed++;
      tick();
    end
  endtask

  task automatic test_backpressure();
    int n;
    a_out_ready = 1'b0;
    a_accept(16'd50, 16'd6);
    a_wait(n);
    total++; if (n !== 16) $display("FAIL bp_latency: got %0d expected 16", n); else passed++;
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({a_ovalid, a_ready, a_quot, a_rem} !== {1'b1, 1'b0, 16'd8, 16'd2})
        $display("FAIL bp_hold%0d: got v=%b r=%b q=%0d rem=%0d expected v=1 r=0 q=8 rem=2", i, a_ovalid, a_ready, a_quot, a_rem);
      else passed++;
      tick();
    end
    total++; if (a_ovalid !== 1'b1) $display("FAIL bp_still_valid: got %b expected 1", a_ovalid); else passed++;
    a_out_ready = 1'b1;
    tick();
    total++; if ({a_ovalid, a_ready} !== 2'b01) $display("FAIL bp_retire: got %b expected 01", {a_ovalid, a_ready}); else passed++;
  endtask

  task automatic test_flush_mid_run();
    int  n;
    logic seen;
    a_out_ready = 1'b1;
    a_accept(16'd200, 16'd3);
    repeat (6) tick();
    a_flush = 1'b1;
    tick();
    a_flush = 1'b0;
    total++; if ({a_ovalid, a_ready, a_busy} !== 3'b010) $display("FAIL flush_idle: got %b expected 010", {a_ovalid, a_ready, a_busy}); else passed++;
    total++; if ({a_quot, a_rem} !== {16'd8, 16'd2}) $display("FAIL flush_keeps_result: got %h expected 00080002", {a_quot, a_rem}); else passed++;
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (a_ovalid === 1'b1) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) $display("FAIL flush_no_valid: got %b expected 0", seen); else passed++;
    a_accept(16'd9, 16'd2);
    a_wait(n);
    total++; if (n !== 16) $display("FAIL flush_next_latency: got %0d expected 16", n); else passed++;
    total++; if ({a_quot, a_rem} !== {16'd4, 16'd1}) $display("FAIL flush_next_result: got %h expected 00040001", {a_quot, a_rem}); else passed++;
    tick();
  endtask

  task automatic test_reset_mid_run();
    a_accept(16'd300, 16'd7);
    repeat (6) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total++; if ({a_ovalid, a_ready, a_busy} !== 3'b010) $display("FAIL rstmid_flags: got %b expected 010", {a_ovalid, a_ready, a_busy}); else passed++;
    total++; if ({a_quot, a_rem} !== 32'h0) $display("FAIL rstmid_result: got %h expected 00000000", {a_quot, a_rem}); else passed++;
    tick();
  endtask

  task automatic test_flush_priority();
    a_dividend = 16'd10;
    a_divisor  = 16'd3;
    a_valid    = 1'b1;
    a_flush    = 1'b1;
    tick();
    a_valid = 1'b0;
    a_flush = 1'b0;
    total++; if ({a_busy, a_ready} !== 2'b01) $display("FAIL flush_valid_idle: got %b expected 01", {a_busy, a_ready}); else passed++;
    a_out_ready = 1'b0;
    a_accept(16'd10, 16'd0);
    total++; if (a_ovalid !== 1'b1) $display("FAIL flush_done_setup: got %b expected 1", a_ovalid); else passed++;
    a_flush = 1'b1;
    tick();
    a_flush = 1'b0;
    total++; if ({a_ovalid, a_ready} !== 2'b01) $display("FAIL flush_in_done: got %b expected 01", {a_ovalid, a_ready}); else passed++;
    a_out_ready = 1'b1;
  endtask

  task automatic test_steps4();
    int n;
    b_out_ready = 1'b1;
    b_accept(16'd1000, 16'd33);
    b_wait(n);
    total++; if (n !== 4) $display("FAIL s4_latency: got %0d expected 4", n); else passed++;
    total++; if ({b_quot, b_rem} !== {16'd30, 16'd10}) $display("FAIL s4_result: got %h expected 001e000a", {b_quot, b_rem}); else passed++;
    tick();
  endtask

  task automatic test_back_to_back();
    int           n, exp_n;
    logic [W-1:0] d, s, eq_v, er_v;
    b_out_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      d = 16'($urandom);
      if ($urandom_range(0, 15) == 0)     s = 16'h0000;
      else if ($urandom_range(0, 1) == 0) s = 16'($urandom_range(1, 255));
      else                                s = 16'($urandom);
      eq_v  = (s == 16'h0000) ? 16'h0000 : d / s;
      er_v  = (s == 16'h0000) ? 16'h0000 : d % s;
      exp_n = (s == 16'h0000) ? 0 : 4;
      b_accept(d, s);
      b_wait(n);
      total++;
      if (n !== exp_n || {b_quot, b_rem} !== {eq_v, er_v})
        $display("FAIL b2b%0d %h/%h: got lat=%0d q=%h r=%h expected lat=%0d q=%h r=%h", i, d, s, n, b_quot, b_rem, exp_n, eq_v, er_v);
      else passed++;
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a_flush = 1'b0; a_valid = 1'b0; a_out_ready = 1'b0; a_dividend = '0; a_divisor = '0;
    b_flush = 1'b0; b_valid = 1'b0; b_out_ready = 1'b0; b_dividend = '0; b_divisor = '0;
    test_reset();
    test_basic();
    test_div_zero();
    test_extremes();
    test_backpressure();
    test_flush_mid_run();
    test_reset_mid_run();
    test_flush_priority();
    test_steps4();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/lc4_div_sequencer.md
Name: lc4_div_sequencer

Overview:
- Multi-cycle iterative unsigned divider controller for DIV (arith subop 011) and MOD (shift subop 11).
- Replaces the single-cycle combinational divide path in the pipelined datapath. The ALU hands operands over with a valid/ready handshake, the block sequences restoring-division steps, and it returns quotient and remainder with output backpressure.
- The pipeline stalls X while o_busy is high.

Parameters:
- WIDTH, 16, operand/result width in bits.
- STEPS_PER_CYCLE, 1, restoring steps done per clock; must divide WIDTH evenly (legal values 1, 2, 4, 8, 16).

Ports:
- clk  in  1  single clock; every state element updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- i_flush  in  1  squash any in-flight operation (branch mispredict).
- i_valid  in  1  operands present.
- o_ready  out  1  block can accept operands.
- i_dividend  in  WIDTH  dividend (r1data).
- i_divisor  in  WIDTH  divisor (r2data).
- o_valid  out  1  result present.
- i_out_ready  in  1  consumer takes the result.
- o_quotient  out  WIDTH  quotient.
- o_remainder  out  WIDTH  remainder.
- o_busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (rst_n=0 at an edge): state becomes IDLE. After that edge: o_ready=1, o_valid=0, o_busy=0, o_quotient=0, o_remainder=0, iteration counter=0.
- States: IDLE, RUN, DONE. All outputs decode from registered state and registered datapath; no combinational path from inputs to outputs.
- IDLE, handshake: o_ready=1. Acceptance is i_valid && o_ready at an edge.
- IDLE, divisor nonzero: latch dividend and divisor; clear rem, quotient and counter; go to RUN.
- IDLE, divisor zero: go straight to DONE with quotient=0 and remainder=0 (LC4 convention). o_valid is high one cycle after the accepting edge.
- RUN, per edge: apply STEPS_PER_CYCLE restoring steps and increment the counter.
- One restoring step:
  - rem_t = {rem[WIDTH-2:0], dvd[WIDTH-1]}; dvd = dvd<<1.
  - If rem_t >= divisor (unsigned): rem = rem_t - divisor and q = {q[WIDTH-2:0],1}.
  - Otherwise: rem = rem_t and q = {q[WIDTH-2:0],0}.
- RUN exit: at the edge where the counter reaches WIDTH/STEPS_PER_CYCLE-1, perform the final steps and go to DONE.
- Latency: o_valid rises exactly WIDTH/STEPS_PER_CYCLE cycles after the accepting edge (16 with the defaults).
- DONE: o_valid=1, o_ready=0. o_quotient and o_remainder are held stable until the edge where i_out_ready=1; then go to IDLE.
- Throughput: a new operation cannot be accepted in the same cycle DONE retires, so there is at least one IDLE cycle between operations.
- o_quotient and o_remainder keep their last values in IDLE until the next operation loads new ones.
- Priority order: reset, then flush, then handshake.
- Flush: i_flush=1 at any edge sends the block to IDLE with o_valid=0.
  - Result registers are not cleared by flush.
  - An i_valid coincident with i_flush in IDLE is not accepted.
  - Flush in DONE discards the result even if i_out_ready=1.
- Reset mid-RUN: abandon the operation and apply the reset values above.
- Operands are unsigned; 0xFFFF is 65535.
- i_dividend and i_divisor are sampled only at the accepting edge; changes during RUN have no effect.

Decomposition:
- Package lc4_div_pkg holds:
  - state enum div_state_t {DIV_IDLE, DIV_RUN, DIV_DONE} (2-bit);
  - localparam DIV_WIDTH=16;
  - counter width function clog2(WIDTH/STEPS_PER_CYCLE).
- Sub-module lc4_div_step: one combinational restoring step, with inputs (dvd, rem, q, divisor) and outputs (dvd', rem', q').
- The sequencer instantiates STEPS_PER_CYCLE chained copies via generate.
- Control FSM and registers stay in lc4_div_sequencer.

Test Plan:
- Basic: accept 100/7, hold i_out_ready=1. o_valid rises 16 cycles after acceptance, quotient 14, remainder 2, then o_ready=1 on the next cycle.
- Divide by zero: accept 0x1234/0. o_valid high one cycle after acceptance with quotient 0 and remainder 0; o_busy falls after retire.
- Extremes: 0xFFFF/1 gives 0xFFFF, 0. 0x0005/0xFFFF gives 0, 5. 0xFFFF/0xFFFF gives 1, 0. 0/3 gives 0, 0.
- Backpressure: 50/6 with i_out_ready=0 for 5 cycles after o_valid. Outputs hold quotient 8, remainder 2 with o_valid=1 and o_ready=0 throughout; the block retires on the first i_out_ready=1 edge.
- Flush/reset mid-op:
  - i_flush at RUN cycle 7 gives IDLE next cycle, o_valid never asserts, and a new 9/2 then yields 4, 1 after 16 cycles.
  - rst_n=0 at cycle 7 gives the reset values.
  - i_flush together with i_valid in IDLE is not accepted.
- STEPS_PER_CYCLE=4: 1000/33 gives quotient 30, remainder 10 with o_valid 4 cycles after acceptance. Back-to-back random operations (1000 vectors) match a reference model of / and %.
